// File: rtl/spi_slave_os.sv
// Oversampled SPI slave: SCK/CS_n/MOSI are synchronised into clk_spi_sample and edge-detected,
// so command/address/data framing, burst read/write and MISO all run on the sample clock.
module spi_slave_os #(
    parameter int unsigned               SPI_MODE        = 0,
    parameter int unsigned               SPI_CMD_LENGTH  = 8,
    parameter logic [SPI_CMD_LENGTH-1:0] SPI_CMD_WR      = 8'h80,
    parameter logic [SPI_CMD_LENGTH-1:0] SPI_CMD_RD      = 8'h81,
    parameter int unsigned               SPI_ADDR_LENGTH = 16,
    parameter int unsigned               SPI_DATA_LENGTH = 16,
    parameter int unsigned               ADDR_AUTO_INC   = 1,
    parameter int unsigned               SYNC_STAGES     = 2
) (
    input  logic                       clk_spi_sample,
    input  logic                       reset_n,
    input  logic                       i_spi_clk,
    input  logic                       i_spi_cs_n,
    input  logic                       i_spi_mosi,
    output logic                       o_spi_miso_data,
    output logic                       o_spi_miso_data_en,
    output logic                       o_wr_en,
    output logic                       o_rd_en,
    output logic                       o_cmd_is_rd,
    output logic [SPI_ADDR_LENGTH-1:0] ov_addr,
    output logic [SPI_DATA_LENGTH-1:0] ov_wr_data,
    input  logic [SPI_DATA_LENGTH-1:0] iv_rd_data,
    input  logic                       i_rd_valid,
    output logic                       o_frame_err
);

    localparam bit          CPOL     = ((SPI_MODE >> 1) & 1) != 0;
    localparam bit          CPHA     = (SPI_MODE & 1) != 0;
    localparam int unsigned MAX_AD   = (SPI_ADDR_LENGTH > SPI_DATA_LENGTH) ?
                                       SPI_ADDR_LENGTH : SPI_DATA_LENGTH;
    localparam int unsigned MAX_LEN  = (SPI_CMD_LENGTH > MAX_AD) ? SPI_CMD_LENGTH : MAX_AD;
    localparam int unsigned CNT_W    = $clog2(MAX_LEN);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(SPI_CMD_LENGTH - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(SPI_ADDR_LENGTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(SPI_DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StWdata,
        StRdata,
        StIgnore
    } state_e;

    // Input synchronisers; CS_n resets low so a CS_n held low across reset is not a fresh fall.
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, cs_prev_q;

    always_ff @(posedge clk_spi_sample or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge, cs_fall, cs_rise;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_fall   = ~sck_s & sck_prev_q;
    assign lead_edge  = CPOL ? sck_fall : sck_rise;
    assign trail_edge = CPOL ? sck_rise : sck_fall;

    // Qualified by the previous CS_n view so an edge coinciding with CS_n rise is still taken.
    assign sample_edge = (CPHA ? trail_edge : lead_edge) & ~cs_prev_q;
    assign shift_edge  = (CPHA ? lead_edge : trail_edge) & ~cs_prev_q;
    assign cs_fall     = cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q & cs_s;

    state_e                     state_q;
    logic [CNT_W-1:0]           bit_cnt_q;
    logic [MAX_LEN-1:0]         sin_q;
    logic [SPI_ADDR_LENGTH-1:0] addr_q;
    logic [SPI_DATA_LENGTH-1:0] wr_data_q;
    logic [SPI_DATA_LENGTH-1:0] hold_q;
    logic [SPI_DATA_LENGTH-1:0] sout_q;
    logic                       hold_vld_q;
    logic                       word_start_q;
    logic                       addr_inc_q;
    logic                       wr_en_q, rd_en_q, is_rd_q, miso_en_q, frame_err_q;

    logic [MAX_LEN-1:0]         sin_next;
    logic [CNT_W-1:0]           field_last;
    logic                       last_bit;
    logic                       partial;

    assign sin_next = {sin_q[MAX_LEN-2:0], mosi_s};

    always_comb begin
        field_last = DATA_LAST;
        case (state_q)
            StCmd:   field_last = CMD_LAST;
            StAddr:  field_last = ADDR_LAST;
            default: field_last = DATA_LAST;
        endcase
    end

    assign last_bit = sample_edge && (bit_cnt_q == field_last);
    // Counter value after this cycle's edge is non-zero: the field is incomplete.
    assign partial  = sample_edge ? (bit_cnt_q != field_last) : (bit_cnt_q != '0);

    always_ff @(posedge clk_spi_sample or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            sin_q        <= '0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            hold_q       <= '0;
            sout_q       <= '0;
            hold_vld_q   <= 1'b0;
            word_start_q <= 1'b0;
            addr_inc_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            is_rd_q      <= 1'b0;
            miso_en_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_inc_q <= 1'b0;
            if (addr_inc_q) begin
                addr_q <= addr_q + 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_q     <= StCmd;
                        bit_cnt_q   <= '0;
                        frame_err_q <= 1'b0;
                    end
                end

                StCmd: begin
                    if (sample_edge) begin
                        sin_q <= sin_next;
                        if (last_bit) begin
                            bit_cnt_q <= '0;
                            if (sin_next[SPI_CMD_LENGTH-1:0] == SPI_CMD_WR) begin
                                state_q <= StAddr;
                                is_rd_q <= 1'b0;
                            end else if (sin_next[SPI_CMD_LENGTH-1:0] == SPI_CMD_RD) begin
                                state_q <= StAddr;
                                is_rd_q <= 1'b1;
                            end else begin
                                state_q     <= StIgnore;
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                StAddr: begin
                    if (sample_edge) begin
                        sin_q <= sin_next;
                        if (last_bit) begin
                            bit_cnt_q <= '0;
                            addr_q    <= sin_next[SPI_ADDR_LENGTH-1:0];
                            if (is_rd_q) begin
                                state_q      <= StRdata;
                                rd_en_q      <= 1'b1;
                                miso_en_q    <= 1'b1;
                                word_start_q <= 1'b1;
                                hold_vld_q   <= 1'b0;
                            end else begin
                                state_q <= StWdata;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                StWdata: begin
                    if (sample_edge) begin
                        sin_q <= sin_next;
                        if (last_bit) begin
                            bit_cnt_q  <= '0;
                            wr_data_q  <= sin_next[SPI_DATA_LENGTH-1:0];
                            wr_en_q    <= 1'b1;
                            addr_inc_q <= (ADDR_AUTO_INC != 0);
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                StRdata: begin
                    if (shift_edge && word_start_q) begin
                        // Word boundary: fresh data wins, then the hold reg, else underrun.
                        word_start_q <= 1'b0;
                        hold_vld_q   <= 1'b0;
                        if (i_rd_valid) begin
                            sout_q <= iv_rd_data;
                        end else if (hold_vld_q) begin
                            sout_q <= hold_q;
                        end else begin
                            sout_q      <= '0;
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        if (shift_edge) begin
                            sout_q <= sout_q << 1;
                        end
                        if (i_rd_valid) begin
                            hold_q     <= iv_rd_data;
                            hold_vld_q <= 1'b1;
                        end
                    end

                    if (sample_edge) begin
                        if (bit_cnt_q == '0) begin
                            rd_en_q <= 1'b1;
                            if (ADDR_AUTO_INC != 0) begin
                                addr_q <= addr_q + 1'b1;
                            end
                        end
                        if (last_bit) begin
                            bit_cnt_q    <= '0;
                            word_start_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                StIgnore: begin
                end

                default: state_q <= StIdle;
            endcase

            if (cs_rise && (state_q != StIdle)) begin
                state_q   <= StIdle;
                miso_en_q <= 1'b0;
                is_rd_q   <= 1'b0;
                if ((state_q == StCmd || state_q == StAddr || state_q == StWdata) && partial) begin
                    frame_err_q <= 1'b1;
                end
            end
        end
    end

    assign o_spi_miso_data    = miso_en_q & sout_q[SPI_DATA_LENGTH-1];
    assign o_spi_miso_data_en = miso_en_q;
    assign o_wr_en            = wr_en_q;
    assign o_rd_en            = rd_en_q;
    assign o_cmd_is_rd        = is_rd_q;
    assign ov_addr            = addr_q;
    assign ov_wr_data         = wr_data_q;
    assign o_frame_err        = frame_err_q;

endmodule

// File: tb/tb_spi_slave_os.sv
// Directed bench for spi_slave_os: one instance per SPI mode, a bit-banged master and a
// small register-bank responder for read frames.
module tb_spi_slave_os;

    localparam int H = 8;  // sample clocks per SCK half period

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  sck;
    logic [3:0]  cs_n;
    logic        mosi;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_data  = 16'h0000;

    logic [3:0]  miso, miso_en, wr_en, rd_en, cmd_is_rd, frame_err;
    logic [15:0] addr    [4];
    logic [15:0] wr_data [4];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_os #(
            .SPI_MODE(g)
        ) u_dut (
            .clk_spi_sample    (clk),
            .reset_n           (reset_n),
            .i_spi_clk         (sck[g]),
            .i_spi_cs_n        (cs_n[g]),
            .i_spi_mosi        (mosi),
            .o_spi_miso_data   (miso[g]),
            .o_spi_miso_data_en(miso_en[g]),
            .o_wr_en           (wr_en[g]),
            .o_rd_en           (rd_en[g]),
            .o_cmd_is_rd       (cmd_is_rd[g]),
            .ov_addr           (addr[g]),
            .ov_wr_data        (wr_data[g]),
            .iv_rd_data        (rd_data),
            .i_rd_valid        (rd_valid),
            .o_frame_err       (frame_err[g])
        );
    end

    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    logic [15:0] rd_addr_log[$];

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (wr_en[g]) begin
                wr_addr_log.push_back(addr[g]);
                wr_data_log.push_back(wr_data[g]);
            end
        end
    end

    // Bank: answers each o_rd_en of instance 0 three clocks later when enabled.
    logic        bank_on = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = 16'h0;

    always @(negedge clk) begin
        rd_valid = 1'b0;
        if (pend_cnt != 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                rd_valid = 1'b1;
                case (pend_addr)
                    16'h0020: rd_data = 16'h1234;
                    16'h0021: rd_data = 16'hBEEF;
                    default:  rd_data = 16'h5A5A;
                endcase
            end
        end
        if (rd_en[0]) begin
            rd_addr_log.push_back(addr[0]);
            if (bank_on) begin
                pend_cnt  = 3;
                pend_addr = addr[0];
            end
        end
    end

    task automatic half();
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_low(input int m);
        cs_n[m] = 1'b0;
        half();
    endtask

    task automatic cs_high(input int m);
        half();
        cs_n[m] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic xfer_bit(input int m, input logic b, output logic r);
        if ((m % 2) == 0) begin
            mosi = b;
            half();
            sck[m] = ~sck[m];
            r = miso[m];
            half();
            sck[m] = ~sck[m];
        end else begin
            sck[m] = ~sck[m];
            mosi = b;
            half();
            sck[m] = ~sck[m];
            r = miso[m];
            half();
        end
    endtask

    task automatic xfer_word(input int m, input int n, input logic [31:0] v,
                             output logic [31:0] r);
        logic b;
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            xfer_bit(m, v[i], b);
            r = {r[30:0], b};
        end
    endtask

    task automatic test_reset();
        logic [37:0] v;
        for (int g = 0; g < 4; g++) begin
            v = {wr_en[g], rd_en[g], cmd_is_rd[g], miso_en[g], miso[g], frame_err[g],
                 addr[g], wr_data[g]};
            tests_run++;
            if (v !== 38'h0) begin
                tests_failed++;
                $display("FAIL reset_outputs mode%0d: got %h expected 0", g, v);
            end
        end
    endtask

    task automatic test_write_mode0();
        logic [31:0] r;
        int base = wr_addr_log.size();
        cs_low(0);
        xfer_word(0, 8, 32'h80, r);
        xfer_word(0, 16, 32'h0010, r);
        xfer_word(0, 16, 32'hA5C3, r);
        cs_high(0);
        tests_run++;
        if (wr_addr_log.size() - base !== 1) begin
            tests_failed++;
            $display("FAIL wr0_count: got %0d expected 1", wr_addr_log.size() - base);
        end else begin
            tests_run++;
            if (wr_addr_log[base] !== 16'h0010) begin
                tests_failed++;
                $display("FAIL wr0_addr: got %h expected 0010", wr_addr_log[base]);
            end
            tests_run++;
            if (wr_data_log[base] !== 16'hA5C3) begin
                tests_failed++;
                $display("FAIL wr0_data: got %h expected a5c3", wr_data_log[base]);
            end
        end
        tests_run++;
        if (frame_err[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr0_err: got %b expected 0", frame_err[0]);
        end
    endtask

    task automatic test_burst_write(input int m);
        logic [31:0] r;
        int base = wr_addr_log.size();
        cs_low(m);
        xfer_word(m, 8, 32'h80, r);
        xfer_word(m, 16, 32'hFFFF, r);
        xfer_word(m, 16, 32'h1111, r);
        xfer_word(m, 16, 32'h2222, r);
        cs_high(m);
        tests_run++;
        if (wr_addr_log.size() - base !== 2) begin
            tests_failed++;
            $display("FAIL burst_wr_count mode%0d: got %0d expected 2", m,
                     wr_addr_log.size() - base);
        end else begin
            tests_run++;
            if ({wr_addr_log[base], wr_data_log[base]} !== 32'hFFFF_1111) begin
                tests_failed++;
                $display("FAIL burst_wr_first mode%0d: got %h/%h expected ffff/1111", m,
                         wr_addr_log[base], wr_data_log[base]);
            end
            tests_run++;
            if ({wr_addr_log[base+1], wr_data_log[base+1]} !== 32'h0000_2222) begin
                tests_failed++;
                $display("FAIL burst_wr_wrap mode%0d: got %h/%h expected 0000/2222", m,
                         wr_addr_log[base+1], wr_data_log[base+1]);
            end
        end
        tests_run++;
        if ({frame_err[m], addr[m]} !== {1'b0, 16'h0001}) begin
            tests_failed++;
            $display("FAIL burst_wr_end mode%0d: got err=%b addr=%h expected err=0 addr=0001",
                     m, frame_err[m], addr[m]);
        end
    endtask

    task automatic test_burst_read();
        logic [31:0] r0, r1, r;
        int base = rd_addr_log.size();
        bank_on = 1'b1;
        cs_low(0);
        xfer_word(0, 8, 32'h81, r);
        tests_run++;
        if ({cmd_is_rd[0], miso_en[0]} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rd_after_cmd: got is_rd=%b miso_en=%b expected 1/0",
                     cmd_is_rd[0], miso_en[0]);
        end
        xfer_word(0, 16, 32'h0020, r);
        xfer_word(0, 16, 32'h0, r0);
        tests_run++;
        if (miso_en[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_miso_en_data: got %b expected 1", miso_en[0]);
        end
        xfer_word(0, 16, 32'h0, r1);
        cs_high(0);
        bank_on = 1'b0;
        tests_run++;
        if (r0[15:0] !== 16'h1234) begin
            tests_failed++;
            $display("FAIL rd_word0: got %h expected 1234", r0[15:0]);
        end
        tests_run++;
        if (r1[15:0] !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL rd_word1: got %h expected beef", r1[15:0]);
        end
        tests_run++;
        if (rd_addr_log.size() - base !== 3) begin
            tests_failed++;
            $display("FAIL rd_req_count: got %0d expected 3", rd_addr_log.size() - base);
        end else begin
            tests_run++;
            if ({rd_addr_log[base], rd_addr_log[base+1], rd_addr_log[base+2]}
                    !== 48'h0020_0021_0022) begin
                tests_failed++;
                $display("FAIL rd_req_addr: got %h %h %h expected 0020 0021 0022",
                         rd_addr_log[base], rd_addr_log[base+1], rd_addr_log[base+2]);
            end
        end
        tests_run++;
        if ({frame_err[0], miso_en[0], cmd_is_rd[0]} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rd_end: got err/miso_en/is_rd=%b expected 000",
                     {frame_err[0], miso_en[0], cmd_is_rd[0]});
        end
    endtask

    task automatic test_underrun();
        logic [31:0] r, d;
        cs_low(0);
        xfer_word(0, 8, 32'h81, r);
        xfer_word(0, 16, 32'h0040, r);
        xfer_word(0, 16, 32'h0, d);
        cs_high(0);
        tests_run++;
        if (d[15:0] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL underrun_data: got %h expected 0000", d[15:0]);
        end
        tests_run++;
        if (frame_err[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL underrun_err: got %b expected 1", frame_err[0]);
        end
        cs_low(0);
        tests_run++;
        if (frame_err[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL underrun_err_clear: got %b expected 0", frame_err[0]);
        end
        cs_high(0);
    endtask

    task automatic test_bad_opcode();
        logic [31:0] r;
        int wbase = wr_addr_log.size();
        int rbase = rd_addr_log.size();
        cs_low(0);
        xfer_word(0, 8, 32'h55, r);
        xfer_word(0, 16, 32'hFFFF, r);
        tests_run++;
        if (miso_en[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL badop_miso_en: got %b expected 0", miso_en[0]);
        end
        xfer_word(0, 16, 32'hFFFF, r);
        cs_high(0);
        tests_run++;
        if ((wr_addr_log.size() - wbase) + (rd_addr_log.size() - rbase) !== 0) begin
            tests_failed++;
            $display("FAIL badop_strobes: got %0d expected 0",
                     (wr_addr_log.size() - wbase) + (rd_addr_log.size() - rbase));
        end
        tests_run++;
        if (frame_err[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL badop_err: got %b expected 1", frame_err[0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        int base = wr_addr_log.size();
        cs_low(0);
        xfer_word(0, 8, 32'h80, r);
        xfer_word(0, 16, 32'h0003, r);
        xfer_word(0, 5, 32'h15, r);
        cs_high(0);
        tests_run++;
        if (wr_addr_log.size() - base !== 0) begin
            tests_failed++;
            $display("FAIL abort_strobe: got %0d expected 0", wr_addr_log.size() - base);
        end
        tests_run++;
        if (frame_err[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_err: got %b expected 1", frame_err[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [37:0] v;
        int base;
        cs_low(0);
        xfer_word(0, 8, 32'h81, r);
        xfer_word(0, 8, 32'h12, r);
        reset_n = 1'b0;
        #1;
        v = {wr_en[0], rd_en[0], cmd_is_rd[0], miso_en[0], miso[0], frame_err[0],
             addr[0], wr_data[0]};
        tests_run++;
        if (v !== 38'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got %h expected 0", v);
        end
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        cs_high(0);
        base = wr_addr_log.size();
        cs_low(0);
        xfer_word(0, 8, 32'h80, r);
        xfer_word(0, 16, 32'h0123, r);
        xfer_word(0, 16, 32'h4567, r);
        cs_high(0);
        tests_run++;
        if (wr_addr_log.size() - base !== 1) begin
            tests_failed++;
            $display("FAIL reset_mid_count: got %0d expected 1", wr_addr_log.size() - base);
        end else begin
            tests_run++;
            if ({wr_addr_log[base], wr_data_log[base]} !== 32'h0123_4567) begin
                tests_failed++;
                $display("FAIL reset_mid_write: got %h/%h expected 0123/4567",
                         wr_addr_log[base], wr_data_log[base]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        sck     = 4'b1100;
        cs_n    = 4'hF;
        mosi    = 1'b0;
        repeat (5) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        test_write_mode0();
        for (int m = 1; m < 4; m++) begin
            test_burst_write(m);
        end
        test_burst_read();
        test_underrun();
        test_bad_opcode();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
